stump_uart_tx_mmio: RTL and testbench

- Memory-mapped UART transmitter on the Stump memory bus.
- Consumes Stump's address, data_out, mem_wen and mem_ren.
- Returns read data for the top-level data_in mux and drives a serial tx line.
- Decouples CPU stores from the serial line through a small byte FIFO, a baud-rate divider and a frame state machine.

---
 rtl/stump_uart_tx_mmio.sv | 186 ++++++++++++++++++
 tb/tb_stump_uart_tx_mmio.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stump_uart_tx_mmio.sv
// Memory-mapped UART transmitter for the Stump bus: byte FIFO, programmable
// baud divider and a start/8-data/stop frame engine driving a registered tx line.
module stump_uart_tx_mmio #(
    parameter logic [15:0] BASE_ADDR  = 16'hFF00,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] DIV_RESET  = 16'd103
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic [15:0] wr_data,
    input  logic        mem_wen,
    input  logic        mem_ren,
    output logic        sel,
    output logic [15:0] rd_data,
    output logic        tx,
    output logic        busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          enable;
    logic [15:0]   baud_div;
    logic [15:0]   baud_cnt;
    state_t        state;
    logic [7:0]    shift;
    logic [2:0]    bit_cnt;

    logic          wr_sel;
    logic          push_req;
    logic          ctrl_wr;
    logic          baud_wr;
    logic          fifo_clear;
    logic          ovf_clear;
    logic          full;
    logic          empty;
    logic          push_ok;
    logic          pop;
    logic [15:0]   status;

    assign sel        = (address[15:2] == BASE_ADDR[15:2]);
    assign wr_sel     = sel && mem_wen;
    assign push_req   = wr_sel && (address[1:0] == 2'd0);
    assign baud_wr    = wr_sel && (address[1:0] == 2'd2);
    assign ctrl_wr    = wr_sel && (address[1:0] == 2'd3);
    assign fifo_clear = ctrl_wr && wr_data[1];
    assign ovf_clear  = ctrl_wr && wr_data[2];

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push_req && !full && !fifo_clear;
    assign pop     = (state == IDLE) && enable && !empty;
    assign busy    = (state != IDLE) || !empty;

    assign status = {7'd0, 5'(count), overflow, busy, empty, full};

    always_comb begin
        rd_data = '0;
        if (sel && mem_ren) begin
            case (address[1:0])
                2'd1:    rd_data = status;
                2'd2:    rd_data = baud_div;
                2'd3:    rd_data = {15'd0, enable};
                default: rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= wr_data[7:0];
        end
    end

    // A push that finds the FIFO full is lost; overflow records it and beats a same-edge clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            baud_div <= DIV_RESET;
            enable   <= 1'b0;
        end else begin
            if (fifo_clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push_ok, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end

            if (push_req && full) begin
                overflow <= 1'b1;
            end else if (ovf_clear) begin
                overflow <= 1'b0;
            end

            if (baud_wr) begin
                baud_div <= wr_data;
            end
            if (ctrl_wr) begin
                enable <= wr_data[0];
            end
        end
    end

    // Each bit lasts baud_div+1 cycles; the divider is re-read at every bit boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            shift    <= '0;
            bit_cnt  <= '0;
            baud_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift    <= fifo_mem[rd_ptr];
                        baud_cnt <= baud_div;
                        tx       <= 1'b0;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= baud_div;
                        bit_cnt  <= '0;
                        tx       <= shift[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                DATA: begin
                    if (baud_cnt == '0) begin
                        baud_cnt <= baud_div;
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        baud_cnt <= baud_cnt - 16'd1;
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stump_uart_tx_mmio.sv
// Scoreboard bench for stump_uart_tx_mmio: expected frames and read values are
// queued by the stimulus and checked by independent tx and read-bus monitors.
module tb_stump_uart_tx_mmio;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] address = '0;
    logic [15:0] wr_data = '0;
    logic        mem_wen = 1'b0;
    logic        mem_ren = 1'b0;
    logic        sel;
    logic [15:0] rd_data;
    logic        tx;
    logic        busy;

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;

    frame_t      exp_frames[$];
    int          frame_starts[$];
    logic [16:0] exp_rd_q[$];
    string       rd_name_q[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    stump_uart_tx_mmio #(
        .BASE_ADDR (16'hFF00),
        .FIFO_DEPTH(4),
        .DIV_RESET (16'd103)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .address(address),
        .wr_data(wr_data),
        .mem_wen(mem_wen),
        .mem_ren(mem_ren),
        .sel    (sel),
        .rd_data(rd_data),
        .tx     (tx),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic writeReg(input logic [15:0] addr, input logic [15:0] data);
        @(posedge clk); #1;
        address = addr;
        wr_data = data;
        mem_wen = 1'b1;
        @(posedge clk); #1;
        mem_wen = 1'b0;
        address = 16'h0000;
    endtask

    task automatic readReg(input logic [15:0] addr, input logic [15:0] exp_data, input logic exp_sel, input string name);
        @(posedge clk); #1;
        address = addr;
        mem_ren = 1'b1;
        exp_rd_q.push_back({exp_sel, exp_data});
        rd_name_q.push_back(name);
        @(posedge clk); #1;
        mem_ren = 1'b0;
        address = 16'h0000;
    endtask

    // Push one byte into TXDATA; queue the frame it should produce when it will be sent.
    task automatic applyStimulus(input logic [15:0] word, input int div, input bit expect_frame);
        frame_t f;
        f.data = word[7:0];
        f.div  = div;
        if (expect_frame) exp_frames.push_back(f);
        writeReg(BASE + 16'd0, word);
    endtask

    task automatic waitIdle(input int max_cycles, input string name);
        int n = 0;
        while (busy && n < max_cycles) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput(name, 32'(busy), 32'd0);
    endtask

    // Read-bus monitor: every cycle with mem_ren asserted is compared against the queued expectation.
    initial begin
        logic [16:0] exp;
        string       nm;
        forever begin
            @(negedge clk);
            if (mem_ren) begin
                if (exp_rd_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL read_unqueued: got 0x%0h, expected no read", {sel, rd_data});
                end else begin
                    exp = exp_rd_q.pop_front();
                    nm  = rd_name_q.pop_front();
                    checkOutput(nm, 32'({sel, rd_data}), 32'(exp));
                end
            end
        end
    end

    // Serial monitor: on a falling tx, samples every cycle of the frame against the queued byte.
    initial begin
        logic       prev_tx;
        frame_t     e;
        int         bad;
        int         b;
        logic       expbit;
        logic [7:0] got;
        logic       got_stop;
        bit         aborted;
        prev_tx = 1'b1;
        forever begin
            @(negedge clk);
            if (rst && prev_tx && !tx) begin
                if (exp_frames.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_frame: got start bit at cycle %0d, expected idle line", cyc);
                end else begin
                    e = exp_frames.pop_front();
                    frame_starts.push_back(cyc);
                    bad      = 0;
                    got      = '0;
                    got_stop = 1'b0;
                    aborted  = 1'b0;
                    for (int k = 0; k < 10 * (e.div + 1); k++) begin
                        if (k != 0) @(negedge clk);
                        if (!rst) begin
                            aborted = 1'b1;
                            break;
                        end
                        b = k / (e.div + 1);
                        if (b == 0)      expbit = 1'b0;
                        else if (b == 9) expbit = 1'b1;
                        else             expbit = e.data[b-1];
                        if (tx !== expbit) bad++;
                        if (k % (e.div + 1) == 0) begin
                            if (b >= 1 && b <= 8) got[b-1] = tx;
                            if (b == 9) got_stop = tx;
                        end
                    end
                    if (!aborted) begin
                        vectors++;
                        if (bad != 0) begin
                            miscompares++;
                            $display("[TB] FAIL frame_%02h: got byte 0x%02h stop %b (%0d bad samples), expected byte 0x%02h stop 1",
                                     e.data, got, got_stop, bad, e.data);
                        end
                    end
                end
            end
            prev_tx = tx;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n0;

        repeat (2) @(negedge clk);
        checkOutput("reset_tx", 32'(tx), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        readReg(BASE + 16'd2, 16'd103, 1'b1, "reset_bauddiv");
        readReg(BASE + 16'd1, 16'h0002, 1'b1, "reset_status");
        readReg(BASE + 16'd3, 16'h0000, 1'b1, "reset_ctrl");
        readReg(BASE + 16'd0, 16'h0000, 1'b1, "txdata_reads_zero");

        // Single frame, 4 cycles per bit.
        writeReg(BASE + 16'd2, 16'd3);
        writeReg(BASE + 16'd3, 16'h0001);
        applyStimulus(16'h12A5, 3, 1'b1);
        checkOutput("tx_high_at_push_edge", 32'(tx), 32'd1);
        @(posedge clk); #1;
        checkOutput("tx_start_bit", 32'(tx), 32'd0);
        checkOutput("busy_in_frame", 32'(busy), 32'd1);
        repeat (39) begin @(posedge clk); #1; end
        checkOutput("busy_last_stop_cycle", 32'(busy), 32'd1);
        @(posedge clk); #1;
        checkOutput("busy_after_40_cycles", 32'(busy), 32'd0);
        checkOutput("tx_idle_after_frame", 32'(tx), 32'd1);

        // Overflow with transmitter disabled.
        writeReg(BASE + 16'd3, 16'h0000);
        writeReg(BASE + 16'd2, 16'd0);
        for (int i = 0; i < 5; i++) applyStimulus(16'h0030 + 16'(i), 0, 1'b0);
        // count=4, overflow, busy (FIFO non-empty), full
        readReg(BASE + 16'd1, 16'h004D, 1'b1, "status_overflow");
        writeReg(BASE + 16'd3, 16'h0004);
        readReg(BASE + 16'd1, 16'h0045, 1'b1, "status_ovf_cleared");
        writeReg(BASE + 16'd3, 16'h0002);
        readReg(BASE + 16'd1, 16'h0002, 1'b1, "status_fifo_cleared");

        // Back-to-back frames at one cycle per bit.
        applyStimulus(16'h0000, 0, 1'b1);
        applyStimulus(16'h00FF, 0, 1'b1);
        n0 = frame_starts.size();
        writeReg(BASE + 16'd3, 16'h0001);
        waitIdle(100, "b2b_idle_timeout");
        checkOutput("b2b_frame_count", 32'(frame_starts.size() - n0), 32'd2);
        if (frame_starts.size() >= n0 + 2)
            checkOutput("b2b_start_spacing", 32'(frame_starts[n0+1] - frame_starts[n0]), 32'd11);

        // fifo_clear while the first of three queued bytes is on the line.
        writeReg(BASE + 16'd2, 16'd3);
        writeReg(BASE + 16'd3, 16'h0000);
        applyStimulus(16'h003C, 3, 1'b1);
        applyStimulus(16'h0081, 3, 1'b0);
        applyStimulus(16'h007E, 3, 1'b0);
        writeReg(BASE + 16'd3, 16'h0001);
        repeat (10) @(posedge clk);
        writeReg(BASE + 16'd3, 16'h0003);
        readReg(BASE + 16'd1, 16'h0006, 1'b1, "status_clear_midframe");
        waitIdle(200, "clear_idle_timeout");
        repeat (20) @(posedge clk);
        readReg(BASE + 16'd1, 16'h0002, 1'b1, "status_after_clear_frame");

        // Asynchronous reset in the middle of the data bits.
        writeReg(BASE + 16'd2, 16'd7);
        applyStimulus(16'h0055, 7, 1'b1);
        repeat (20) @(posedge clk);
        #3;
        checkOutput("tx_low_before_reset", 32'(tx), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("tx_after_async_reset", 32'(tx), 32'd1);
        checkOutput("busy_after_async_reset", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        readReg(BASE + 16'd2, 16'd103, 1'b1, "bauddiv_after_reset");
        readReg(BASE + 16'd1, 16'h0002, 1'b1, "status_after_reset");
        readReg(BASE + 16'd3, 16'h0000, 1'b1, "ctrl_after_reset");

        // Addresses just outside the window.
        readReg(BASE + 16'd4, 16'h0000, 1'b0, "decode_above");
        readReg(BASE - 16'd1, 16'h0000, 1'b0, "decode_below");
        writeReg(BASE + 16'd4, 16'h00AA);
        writeReg(BASE - 16'd1, 16'h0007);
        writeReg(BASE + 16'd6, 16'h1234);
        readReg(BASE + 16'd2, 16'd103, 1'b1, "decode_bauddiv_kept");
        readReg(BASE + 16'd1, 16'h0002, 1'b1, "decode_status_kept");
        readReg(BASE + 16'd3, 16'h0000, 1'b1, "decode_ctrl_kept");
        checkOutput("decode_tx_idle", 32'(tx), 32'd1);

        repeat (20) @(posedge clk);
        checkOutput("frames_outstanding", 32'(exp_frames.size()), 32'd0);
        checkOutput("reads_outstanding", 32'(exp_rd_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
